// File: rtl/reg_pipe.sv
// reg_pipe -- DEPTH-stage valid/ready register pipeline with bubble collapse.
//
// Each stage holds one valid bit and one WIDTH-bit data register. A stage
// loads from its upstream neighbour whenever it is empty or its downstream
// neighbour advances, so bubbles are squeezed out while the output is stalled
// and the pipe can hold DEPTH items. The output side comes straight from the
// last stage registers. The ready chain is combinational from m_ready.
//
// Parameters:
//   WIDTH  data width in bits (1..256)
//   DEPTH  number of register stages (1..16)
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears valid and data)
//   flush      synchronous clear of all valid bits; blocks input transfers
//   s_valid    upstream offers s_data
//   s_ready    block accepts s_data this cycle
//   s_data     upstream payload
//   m_valid    m_data holds a valid item
//   m_ready    downstream accepts m_data this cycle
//   m_data     payload from the last stage
//   occupancy  count of valid stages (only when REG_PIPE_OCC_EN is defined)
//
// Build option: define REG_PIPE_OCC_EN to add the occupancy port and counter.
module reg_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [WIDTH-1:0]            s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [WIDTH-1:0]            m_data
`ifdef REG_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy
`endif
);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            adv;     // stage i loads from its upstream this cycle
  logic [DEPTH-1:0]            prev_v;  // upstream valid seen by each stage
  logic [DEPTH-1:0][WIDTH-1:0] prev_d;  // upstream data seen by each stage

  // A stage can advance when m_ready is high or any stage from it to the
  // output is empty. Computed from state directly (not chained through adv)
  // so there is no combinational self-reference across the vector.
  always_comb begin
    prev_v    = '0;
    prev_d    = '0;
    adv       = '0;
    prev_v[0] = s_valid;
    prev_d[0] = s_data;
    for (int i = 1; i < DEPTH; i++) begin
      prev_v[i] = valid_q[i-1];
      prev_d[i] = data_q[i-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      logic a;
      a = m_ready;
      for (int j = i; j < DEPTH; j++) a = a | ~valid_q[j];
      adv[i] = a;
    end
  end

  // rst_n gates s_ready so nothing is offered as accepted while held in reset.
  assign s_ready = rst_n & ~flush & adv[0];

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush)       valid_d[i] = 1'b0;
      else if (adv[i]) valid_d[i] = prev_v[i];
      // Data only moves with a valid item; stale data after flush is harmless.
      if (adv[i] && prev_v[i]) data_d[i] = prev_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign m_valid = valid_q[DEPTH-1];
  assign m_data  = data_q[DEPTH-1];

`ifdef REG_PIPE_OCC_EN
  localparam int OW = $clog2(DEPTH+1);

  logic          in_xfer, out_xfer;
  logic [OW-1:0] occ_q, occ_d;

  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;

  // Simultaneous in and out leave the count unchanged; flush wins over both.
  always_comb begin
    occ_d = occ_q;
    if (flush)                     occ_d = '0;
    else if (in_xfer && !out_xfer) occ_d = occ_q + OW'(1);
    else if (!in_xfer && out_xfer) occ_d = occ_q - OW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occupancy = occ_q;
`else
  // No occupancy tracking in this build.
`endif

endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal range 1..256.
REQ-002 Parameter DEPTH, default 2, number of register stages; legal range 1..16.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 flush  input  1  synchronous clear of all stage contents.
REQ-006 s_valid  input  1  upstream offers s_data.
REQ-007 s_ready  output  1  block accepts s_data this cycle.
REQ-008 s_data  input  WIDTH  upstream payload.
REQ-009 m_valid  output  1  m_data holds a valid item.
REQ-010 m_ready  input  1  downstream accepts m_data this cycle.
REQ-011 m_data  output  WIDTH  payload from the last stage.
REQ-012 occupancy  output  $clog2(DEPTH+1)  number of valid stages; present only under REG_PIPE_OCC_EN.

Function
REQ-013 Stages 0..DEPTH-1: each stage SHALL hold one valid bit and one WIDTH-bit data register.
REQ-014 Transfers: an input transfer SHALL occur when s_valid && s_ready; an output transfer SHALL occur when m_valid && m_ready.
REQ-015 m_valid and m_data SHALL be driven directly from stage DEPTH-1 registers, with no combinational path from s_data.
REQ-016 Stage i advance: stage i SHALL load from stage i-1 (or from s_data for i=0) when stage i is empty, or when stage i+1 advances (for i=DEPTH-1, when m_ready).
REQ-017 Bubble collapse: empty stages SHALL be filled while downstream is stalled, so that DEPTH items can be held under sustained m_ready=0.
REQ-018 s_ready SHALL be high exactly when stage 0 can load this cycle and flush=0; the ready chain is combinational from m_ready.
REQ-019 Latency: an item accepted at edge E, with no stall, SHALL appear on m_valid/m_data after edge E+DEPTH-1; throughput SHALL be one item per cycle.
REQ-020 Order: items SHALL leave in acceptance order, with no loss, duplication or data change.
REQ-021 Hold: while m_valid=1 and m_ready=0, m_data SHALL stay stable.
REQ-022 Full: with all stages valid and m_ready=0, s_ready SHALL be 0.
REQ-023 Simultaneous full and m_ready=1: s_ready SHALL be 1, and the input and output transfers SHALL complete in the same cycle.
REQ-024 Flush priority: when flush=1 at an edge, all valid bits SHALL clear; no input transfer SHALL occur.
REQ-025 Output during flush: an output transfer in the flush cycle SHALL count as completed.
REQ-026 Data after flush: data registers MAY retain stale values after a flush; m_data is don't-care while m_valid=0.

Reset
REQ-027 rst_n=0 SHALL immediately clear all stage valid bits and data registers to 0, independent of clk.
REQ-028 During reset, m_valid=0, m_data=0 and s_ready=0; occupancy=0 when present.
REQ-029 Deassertion: first acceptance SHALL be possible on the first rising edge after rst_n deasserts.
REQ-030 Mid-operation reset: rst_n asserted mid-operation SHALL discard all in-flight items; no partial item may emerge after release.

Configuration
REQ-031 Macro REG_PIPE_OCC_EN defined: the occupancy port SHALL exist and equal the count of valid stages after each edge.
REQ-032 Occupancy update: occupancy SHALL be incremented on input transfer and decremented on output transfer, with no change when both occur; it SHALL be cleared to 0 by flush and by reset.
REQ-033 REG_PIPE_OCC_EN undefined: the occupancy port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 WIDTH=8, DEPTH=3, m_ready=1, s_valid=1 with data 0x01,0x02,0x03... -> m_valid rises after edge 3 (latency DEPTH-1 edges after accept); 0x01,0x02,0x03 leave on consecutive cycles.
REQ-035 m_ready=0, push 0xA0..0xA3 -> 3 accepted, s_ready=0 on 4th; occupancy=3; m_data holds 0xA0; m_ready=1 -> 0xA0,0xA1,0xA2 then 0xA3 in order.
REQ-036 Pipe full, m_ready=1, s_valid=1 with 0x55 -> same-cycle in/out; occupancy stays 3; 0x55 appears in order later.
REQ-037 Two items in flight, flush=1 with s_valid=1 -> next cycle m_valid=0, occupancy=0; the offered item is not accepted.
REQ-038 rst_n pulsed low between edges while 2 items are valid -> m_valid=0 at once; after release, no old item appears and s_ready=1.
REQ-039 Random s_valid/m_ready at DEPTH=1 and DEPTH=16 for 10k cycles -> scoreboard shows exact in-order match with no drops.
